instr_store: RTL and testbench

Parametrised instruction store feeding the datapath fetch path. It is the next generation of the 16×8 instruction memory. The block:
- loads a program through a valid/ready stream with an auto-incrementing write pointer, instead of pc-addressed writes;
- tracks program length and reports full;
- clears itself with a timed sweep after reset or on request;
- serves fetches through a registered read port that returns NOP (zero) for any pc outside the loaded program.

Address 0 stays reserved (never loaded) unless `BASE_ADDR` is set to 0.

---
 rtl/instr_store.sv | 123 ++++++++++++
 tb/tb_instr_store.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_store.sv
// instr_store: instruction memory with streamed program load, clear sweep
// and a registered fetch port that returns NOP outside the loaded program.
module instr_store #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              state,
  input  logic              clr,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid,
  output logic [ADDR_W:0]   prog_len,
  output logic              full,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] BASE =
    (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] CAP =
    (ADDR_W+1)'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_RUN
  } st_t;

  st_t st;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] sweep;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   lim;
  logic [ADDR_W:0]   pc_x;
  logic              xfer;
  logic              in_range;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  assign full       = (prog_len == CAP);
  assign busy       = (st == S_CLEAR);
  assign load_ready = (st == S_LOAD) & ~state & ~full;
  assign xfer       = load_valid & load_ready;

  // one extra bit so BASE + prog_len == DEPTH stays representable
  assign lim      = BASE + prog_len;
  assign pc_x     = {1'b0, pc};
  assign in_range = (pc_x >= BASE) && (pc_x < lim);

  always_comb begin
    we = 1'b0;
    wa = sweep;
    wd = '0;
    if (!rst) begin
      if (st == S_CLEAR) begin
        we = 1'b1;
      end else if (xfer) begin
        we = 1'b1;
        wa = wr_ptr[ADDR_W-1:0];
        wd = instr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_CLEAR;
      sweep       <= '0;
      wr_ptr      <= BASE;
      prog_len    <= '0;
      instr_o     <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_o     <= '0;
      instr_valid <= 1'b0;
      unique case (st)
        S_CLEAR: begin
          sweep <= sweep + 1'b1;
          if (sweep == LAST)
            st <= state ? S_RUN : S_LOAD;
        end
        S_LOAD: begin
          if (clr) begin
            st       <= S_CLEAR;
            sweep    <= '0;
            wr_ptr   <= BASE;
            prog_len <= '0;
          end else begin
            if (xfer) begin
              wr_ptr   <= wr_ptr + 1'b1;
              prog_len <= prog_len + 1'b1;
            end
            if (state) st <= S_RUN;
          end
        end
        S_RUN: begin
          if (!state) begin
            st <= S_LOAD;
          end else if (in_range) begin
            instr_o     <= mem[pc];
            instr_valid <= 1'b1;
          end
        end
        default: st <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_store.sv
// tb_instr_store: directed checks of sweep, load, full, gaps,
// append/clear and reset restart for instr_store with defaults.
module tb_instr_store;

  logic       clk = 1'b0;
  logic       rst;
  logic       state;
  logic       clr;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] instr_i;
  logic [3:0] pc;
  logic [7:0] instr_o;
  logic       instr_valid;
  logic [4:0] prog_len;
  logic       full;
  logic       busy;

  int total = 0;
  int bad   = 0;

  instr_store dut (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .clr         (clr),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .instr_i     (instr_i),
    .pc          (pc),
    .instr_o     (instr_o),
    .instr_valid (instr_valid),
    .prog_len    (prog_len),
    .full        (full),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts cycles with busy high, starting at the current one
  task automatic wait_sweep(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check(tag, n, 16);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", busy, 1);
    wait_sweep("clr_sweep");
  endtask

  task automatic push(input logic [7:0] w);
    load_valid = 1'b1;
    instr_i    = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [3:0] a,
                       input logic [7:0] ed, input logic ev);
    pc = a;
    tick();
    check({tag, "_d"}, instr_o, ed);
    check({tag, "_v"}, instr_valid, ev);
  endtask

  task automatic to_run();
    state = 1'b1;
    tick();
    check("trans_instr", instr_o, 0);
  endtask

  task automatic to_load();
    state = 1'b0;
    tick();
    check("load_instr_v", instr_valid, 0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] gap_v;
    int acc;

    rst = 1'b0; state = 1'b0; clr = 1'b0;
    load_valid = 1'b0; instr_i = '0; pc = '0;

    // reset sweep
    do_reset();
    check("rst_instr", instr_o, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_ready", load_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_len", prog_len, 0);
    check("rst_full", full, 0);
    wait_sweep("rst_sweep");
    check("post_ready", load_ready, 1);
    to_run();
    for (int i = 0; i < 16; i++)
      fetch("empty", 4'(i), 8'h00, 1'b0);
    to_load();

    // load and fetch
    push(8'hA1);
    load_valid = 1'b1; instr_i = 8'hB2; tick();
    instr_i = 8'hC3; tick();
    load_valid = 1'b0;
    check("lf_len", prog_len, 3);
    to_run();
    fetch("lf1", 4'd1, 8'hA1, 1'b1);
    fetch("lf2", 4'd2, 8'hB2, 1'b1);
    fetch("lf3", 4'd3, 8'hC3, 1'b1);
    fetch("lf4", 4'd4, 8'h00, 1'b0);
    fetch("lf0", 4'd0, 8'h00, 1'b0);
    to_load();
    check("rl_instr", instr_o, 0);

    // full
    do_clr();
    check("full_len0", prog_len, 0);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (load_ready) acc++;
      push(8'h10 + 8'(i));
    end
    check("full_acc", acc, 15);
    check("full_flag", full, 1);
    check("full_ready", load_ready, 0);
    check("full_len", prog_len, 15);
    to_run();
    fetch("full1", 4'd1, 8'h10, 1'b1);
    fetch("full15", 4'd15, 8'h1E, 1'b1);
    fetch("full0", 4'd0, 8'h00, 1'b0);
    to_load();

    // backpressure / gaps
    do_clr();
    gap_v = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      load_valid = gap_v[i];
      instr_i    = 8'h40 + 8'(i);
      if (gap_v[i]) exp_q.push_back(instr_i);
      tick();
    end
    load_valid = 1'b1;
    instr_i    = 8'hEE;
    state      = 1'b1;
    tick();
    load_valid = 1'b0;
    check("gap_len", prog_len, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      fetch("gap", 4'(i + 1), exp_q[i], 1'b1);
    fetch("gap_end", 4'(exp_q.size() + 1), 8'h00, 1'b0);
    to_load();

    // clear and append
    do_clr();
    push(8'h51);
    push(8'h52);
    to_run();
    to_load();
    push(8'h53);
    check("app_len", prog_len, 3);
    to_run();
    fetch("app1", 4'd1, 8'h51, 1'b1);
    fetch("app2", 4'd2, 8'h52, 1'b1);
    fetch("app3", 4'd3, 8'h53, 1'b1);
    to_load();
    clr = 1'b1; state = 1'b1;
    tick();
    clr = 1'b0;
    check("cs_busy", busy, 1);
    wait_sweep("cs_sweep");
    check("cs_len", prog_len, 0);
    fetch("cs_pc1", 4'd1, 8'h00, 1'b0);
    to_load();

    // reset mid-load
    for (int i = 0; i < 5; i++)
      push(8'h60 + 8'(i));
    check("ml_len5", prog_len, 5);
    do_reset();
    wait_sweep("ml_sweep");
    check("ml_len", prog_len, 0);

    // reset mid-sweep at sweep address 7
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    check("ms_busy", busy, 1);
    do_reset();
    wait_sweep("ms_sweep");
    check("ms_len", prog_len, 0);
    check("ms_ready", load_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
